// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation ADC controller for the Pmod ADC front end.
//
// For each result bit the controller:
//   - builds a trial code,
//   - shifts it MSB-first into an external serial DAC shift register,
//   - latches it,
//   - waits for the comparator to settle,
//   - then keeps or clears the trial bit.
// The sample-and-hold tracks while idle and during acquisition, and holds from
// the first shifted bit until the result is published.
//
// Ports:
//   clk_i, reset_i   system clock, synchronous active-high reset
//   start_i          single-shot request (honoured only in IDLE)
//   cont_i           continuous mode (checked in IDLE and DONE)
//   sh_o             sample/hold, 1 = track, 0 = hold
//   ser_o            serial DAC data, MSB first
//   sclk_o           DAC shift clock (register shifts on rising edge)
//   lclk_o           DAC latch clock (register latches on rising edge)
//   comp_i           comparator, 1 = trial level <= input
//   busy_o           conversion in progress (ACQ through DONE)
//   result_o         last completed code
//   result_valid_o   result_o holds an unconsumed code
//   result_ready_i   consumer accept
//   overrun_o        one-cycle pulse when an unconsumed result is overwritten
//
// All pin-facing outputs come straight from flops, so the DAC and S/H lines
// never see decode glitches.

module sar_adc_ctrl #(
  parameter int unsigned WIDTH      = 14,
  parameter int unsigned SHREG_W    = 16,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned ACQ_CYC    = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             cont_i,
  output logic             sh_o,
  output logic             ser_o,
  output logic             sclk_o,
  output logic             lclk_o,
  input  logic             comp_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] result_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic             overrun_o
);

  // One phase counter is shared by ACQ, the SClk half-periods, LATCH and
  // SETTLE, so it is sized for the longest of them.
  localparam int unsigned CNT_A   = (ACQ_CYC > CLK_DIV) ? ACQ_CYC : CLK_DIV;
  localparam int unsigned CNT_MAX = (CNT_A > SETTLE_CYC) ? CNT_A : SETTLE_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned BC_W    = (SHREG_W > 1) ? $clog2(SHREG_W) : 1;

  localparam logic [CNT_W-1:0] ACQ_LAST    = CNT_W'(ACQ_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [BC_W-1:0]  BC_LAST     = BC_W'(SHREG_W - 1);
  localparam logic [BIT_W-1:0] BIT_TOP     = BIT_W'(WIDTH - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACQ    = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_LATCH  = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_DECIDE = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  logic [2:0]         state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [BC_W-1:0]    bitcnt_q, bitcnt_d;
  logic [BIT_W-1:0]   bit_q,    bit_d;
  logic [WIDTH-1:0]   code_q,   code_d;
  logic [SHREG_W-1:0] shreg_q,  shreg_d;
  logic               sh_q,     sh_d;
  logic               sclk_q,   sclk_d;
  logic               lclk_q,   lclk_d;
  logic               busy_q,   busy_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               valid_q,  valid_d;
  logic               ovr_q,    ovr_d;
  logic [WIDTH-1:0]   code_dec;

  // Trial word: decided bits plus the bit under test, left-aligned in the
  // external register with zero padding below.
  function automatic logic [SHREG_W-1:0] trial_word(input logic [WIDTH-1:0] code,
                                                    input logic [BIT_W-1:0] b);
    logic [SHREG_W-1:0] w;
    w = '0;
    w[SHREG_W-1 -: WIDTH] = code | (WIDTH'(1) << b);
    return w;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    bit_d    = bit_q;
    code_d   = code_q;
    shreg_d  = shreg_q;
    sh_d     = sh_q;
    sclk_d   = sclk_q;
    lclk_d   = lclk_q;
    busy_d   = busy_q;
    result_d = result_q;
    valid_d  = valid_q;
    ovr_d    = 1'b0;
    code_dec = comp_i ? (code_q | (WIDTH'(1) << bit_q)) : code_q;

    // Consumer accept; a DONE load in the same cycle overrides this below.
    if (valid_q && result_ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        sh_d = 1'b1;
        if (start_i || cont_i) begin
          state_d = ST_ACQ;
          busy_d  = 1'b1;
          cnt_d   = '0;
          code_d  = '0;
          bit_d   = BIT_TOP;
        end
      end

      ST_ACQ: begin
        if (cnt_q == ACQ_LAST) begin
          state_d  = ST_SHIFT;
          sh_d     = 1'b0;
          cnt_d    = '0;
          bitcnt_d = '0;
          sclk_d   = 1'b0;
          shreg_d  = trial_word(code_q, bit_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Each bit is a low half then a high half of SClk. The register
      // advances together with the falling edge, so ser_o only changes while
      // SClk is low and stays stable across the rising edge. Shifting in
      // zeros leaves the register empty once the word is out, which returns
      // ser_o low outside SHIFT.
      ST_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d  = 1'b0;
            shreg_d = shreg_q << 1;
            if (bitcnt_q == BC_LAST) begin
              bitcnt_d = '0;
              state_d  = ST_LATCH;
              lclk_d   = 1'b1;
            end else begin
              bitcnt_d = bitcnt_q + BC_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_LATCH: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          lclk_d  = 1'b0;
          state_d = (SETTLE_CYC == 0) ? ST_DECIDE : ST_SETTLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_DECIDE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DECIDE: begin
        code_d = code_dec;
        if (bit_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d  = ST_SHIFT;
          bit_d    = bit_q - BIT_W'(1);
          cnt_d    = '0;
          bitcnt_d = '0;
          sclk_d   = 1'b0;
          shreg_d  = trial_word(code_dec, bit_q - BIT_W'(1));
        end
      end

      ST_DONE: begin
        result_d = code_q;
        valid_d  = 1'b1;
        ovr_d    = valid_q && !result_ready_i;
        sh_d     = 1'b1;
        cnt_d    = '0;
        if (cont_i) begin
          state_d = ST_ACQ;
          code_d  = '0;
          bit_d   = BIT_TOP;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        sh_d    = 1'b1;
        busy_d  = 1'b0;
        sclk_d  = 1'b0;
        lclk_d  = 1'b0;
        shreg_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      bit_q    <= '0;
      code_q   <= '0;
      shreg_q  <= '0;
      sh_q     <= 1'b1;
      sclk_q   <= 1'b0;
      lclk_q   <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      bit_q    <= bit_d;
      code_q   <= code_d;
      shreg_q  <= shreg_d;
      sh_q     <= sh_d;
      sclk_q   <= sclk_d;
      lclk_q   <= lclk_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign sh_o           = sh_q;
  assign ser_o          = shreg_q[SHREG_W-1];
  assign sclk_o         = sclk_q;
  assign lclk_o         = lclk_q;
  assign busy_o         = busy_q;
  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Testbench for sar_adc_ctrl: default 14/16-bit instance plus an 8/8-bit
// instance, each driving a model of the serial DAC and a threshold comparator.

module tb_sar_adc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, cont, ready;
  logic sh, ser, sclk, lclk, comp, busy, valid, ovr;
  logic [13:0] result;

  logic start8, ready8;
  logic sh8, ser8, sclk8, lclk8, comp8, busy8, valid8, ovr8;
  logic [7:0] result8;

  sar_adc_ctrl u_dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .cont_i(cont),
    .sh_o(sh), .ser_o(ser), .sclk_o(sclk), .lclk_o(lclk), .comp_i(comp),
    .busy_o(busy), .result_o(result), .result_valid_o(valid),
    .result_ready_i(ready), .overrun_o(ovr)
  );

  sar_adc_ctrl #(.WIDTH(8), .SHREG_W(8), .CLK_DIV(1), .SETTLE_CYC(0), .ACQ_CYC(8)) u_dut8 (
    .clk_i(clk), .reset_i(reset), .start_i(start8), .cont_i(1'b0),
    .sh_o(sh8), .ser_o(ser8), .sclk_o(sclk8), .lclk_o(lclk8), .comp_i(comp8),
    .busy_o(busy8), .result_o(result8), .result_valid_o(valid8),
    .result_ready_i(ready8), .overrun_o(ovr8)
  );

  // DAC model, 16-bit instance
  logic [1:0]  mode = 2'd0;      // 0 = threshold, 1 = tied high, 2 = tied low
  logic [15:0] thr  = 16'h2A52;
  logic [15:0] sr   = '0;
  logic [15:0] dac  = '0;
  int unsigned sclk_cnt = 0;
  int unsigned lclk_cnt = 0;
  logic [15:0] word_log[$];

  always @(posedge sclk) begin
    sr <= {sr[14:0], ser};
    sclk_cnt <= sclk_cnt + 1;
  end
  always @(posedge lclk) begin
    dac <= sr;
    word_log.push_back(sr);
    lclk_cnt <= lclk_cnt + 1;
  end
  assign comp = (mode == 2'd1) ? 1'b1 : (mode == 2'd2) ? 1'b0 : (dac <= thr);

  // DAC model, 8-bit instance
  logic [7:0] sr8  = '0;
  logic [7:0] dac8 = '0;
  int unsigned sclk8_cnt = 0;
  int unsigned lclk8_cnt = 0;
  always @(posedge sclk8) begin
    sr8 <= {sr8[6:0], ser8};
    sclk8_cnt <= sclk8_cnt + 1;
  end
  always @(posedge lclk8) begin
    dac8 <= sr8;
    lclk8_cnt <= lclk8_cnt + 1;
  end
  assign comp8 = (dac8 <= 8'h5B);

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] thr;
    logic [13:0] exp_res;
    logic [15:0] exp_first;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, n, base_l, base_s, base_lc;
    logic prev_busy, ovr_seen, valid_drop;

    vecs[0] = '{2'd0, 16'h2A52, 14'h0A94, 16'h8000};
    vecs[1] = '{2'd1, 16'h0000, 14'h3FFF, 16'h8000};
    vecs[2] = '{2'd2, 16'h0000, 14'h0000, 16'h8000};
    vecs[3] = '{2'd0, 16'hFFFF, 14'h3FFF, 16'h8000};
    vecs[4] = '{2'd0, 16'h0004, 14'h0001, 16'h8000};
    vecs[5] = '{2'd0, 16'h0003, 14'h0000, 16'h8000};

    reset = 1'b1; start = 1'b0; cont = 1'b0; ready = 1'b0;
    start8 = 1'b0; ready8 = 1'b0;
    repeat (3) tick();
    check("rst_sh", 32'(sh), 32'd1);
    check("rst_ser", 32'(ser), 32'd0);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_lclk", 32'(lclk), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    reset = 1'b0;
    tick();

    // Table of single-shot conversions
    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].mode;
      thr  = vecs[i].thr;
      base_l = word_log.size(); base_s = sclk_cnt; base_lc = lclk_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      check($sformatf("v%0d_busy_acq", i), 32'(busy), 32'd1);
      check($sformatf("v%0d_sh_acq", i), 32'(sh), 32'd1);
      cyc = 0; prev_busy = 1'b1;
      while (!valid && cyc < 2000) begin
        prev_busy = busy;
        tick();
        cyc++;
      end
      check($sformatf("v%0d_latency", i), 32'(cyc), 32'd1003);
      check($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].exp_res));
      check($sformatf("v%0d_busy_done", i), 32'(prev_busy), 32'd1);
      check($sformatf("v%0d_busy_fall", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_sclk_edges", i), 32'(sclk_cnt - base_s), 32'd224);
      check($sformatf("v%0d_lclk_edges", i), 32'(lclk_cnt - base_lc), 32'd14);
      if (word_log.size() > base_l)
        check($sformatf("v%0d_first_word", i), 32'(word_log[base_l]), 32'(vecs[i].exp_first));
      else
        check($sformatf("v%0d_first_word_missing", i), 32'(word_log.size()), 32'(base_l + 1));
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check($sformatf("v%0d_consumed", i), 32'(valid), 32'd0);
      tick();
    end

    // Continuous mode, consumer always ready
    mode = 2'd0; thr = 16'h2A52;
    ready = 1'b1; cont = 1'b1;
    tick();
    cyc = 0; ovr_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      while (!valid && cyc < 2000) begin
        tick();
        cyc++;
        if (ovr) ovr_seen = 1'b1;
      end
      check($sformatf("cont%0d_period", k), 32'(cyc), 32'd1003);
      check($sformatf("cont%0d_result", k), 32'(result), 32'h0A94);
      n = 0;
      while (sh && n < 20) begin
        n++;
        tick();
        if (ovr) ovr_seen = 1'b1;
      end
      check($sformatf("cont%0d_sh_track", k), 32'(n), 32'd8);
      cyc = n;
    end
    cont = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
      if (ovr) ovr_seen = 1'b1;
    end
    check("cont_stop_idle", 32'(busy), 32'd0);
    check("cont_last_result", 32'(result), 32'h0A94);
    check("cont_no_overrun", 32'(ovr_seen), 32'd0);
    tick();
    ready = 1'b0;
    tick();

    // Continuous mode, consumer stalled
    cont = 1'b1;
    tick();
    cyc = 0;
    while (!valid && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("ovr_first_latency", 32'(cyc), 32'd1003);
    check("ovr_first_no_pulse", 32'(ovr), 32'd0);
    cyc = 0; valid_drop = 1'b0;
    while (!ovr && cyc < 2000) begin
      tick();
      cyc++;
      if (!valid) valid_drop = 1'b1;
    end
    check("ovr_second_period", 32'(cyc), 32'd1003);
    check("ovr_valid_held", 32'(valid_drop), 32'd0);
    check("ovr_valid_on_pulse", 32'(valid), 32'd1);
    check("ovr_result", 32'(result), 32'h0A94);
    tick();
    check("ovr_one_cycle", 32'(ovr), 32'd0);
    check("ovr_valid_after", 32'(valid), 32'd1);
    repeat (1001) tick();
    check("ovr_done_busy", 32'(busy), 32'd1);
    check("ovr_done_hold", 32'(sh), 32'd0);
    ready = 1'b1; cont = 1'b0;
    tick();
    check("ready_in_done_no_ovr", 32'(ovr), 32'd0);
    check("ready_in_done_valid", 32'(valid), 32'd1);
    check("ready_in_done_idle", 32'(busy), 32'd0);
    tick();
    check("ready_in_done_consumed", 32'(valid), 32'd0);
    ready = 1'b0;
    tick();

    // Reset during the 7th bit's shift phase
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (444) tick();
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_hold", 32'(sh), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_sh", 32'(sh), 32'd1);
    check("abort_ser", 32'(ser), 32'd0);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_lclk", 32'(lclk), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    n = 0;
    for (int c = 0; c < 1100; c++) begin
      tick();
      if (valid || busy) n++;
    end
    check("abort_stays_idle", 32'(n), 32'd0);

    // Conversion after the abort; a start pulse while busy must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!valid && cyc < 2000) begin
      if (cyc == 200) start = 1'b1;
      else start = 1'b0;
      tick();
      cyc++;
    end
    start = 1'b0;
    check("post_abort_latency", 32'(cyc), 32'd1003);
    check("post_abort_result", 32'(result), 32'h0A94);
    n = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (busy) n++;
    end
    check("busy_start_ignored", 32'(n), 32'd0);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    // Narrow parameter set
    base_s = sclk8_cnt; base_lc = lclk8_cnt;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    cyc = 0;
    while (!valid8 && cyc < 1000) begin
      tick();
      cyc++;
    end
    check("w8_latency", 32'(cyc), 32'd153);
    check("w8_result", 32'(result8), 32'h5B);
    check("w8_sclk_edges", 32'(sclk8_cnt - base_s), 32'd64);
    check("w8_lclk_edges", 32'(lclk8_cnt - base_lc), 32'd8);
    check("w8_busy_fall", 32'(busy8), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
